// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// the ebreak encoding that halts fetch, and the default boot PC.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  function automatic logic is_ebreak(input logic [31:0] inst);
    return inst == EBREAK_INST;
  endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch: issues one request per PC, holds the
// returned word for the downstream stage, and handles redirects and ebreak halt.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | one cycle after reset release, nothing issued
//   REQ    | presenting PC on imem request (suppressed while redirecting)
//   WAIT   | request accepted, waiting for the single-cycle response
//   OUT    | instruction held for downstream until out handshake
//   HALT   | ebreak delivered; fetch stopped until reset
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC[XLEN-1:0]
) (
  input  logic            clock,
  input  logic            reset,

  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,

  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,

  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,

  output logic            halt,
  output logic [63:0]     fetch_count
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic            halt_q, halt_d;
  logic [63:0]     cnt_q, cnt_d;
  logic [31:0]     inst_q, inst_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;

  logic [XLEN-1:0] redir_tgt;
  logic [XLEN-1:0] pc_next_seq;

  // Targets are always word aligned; the low bits of redirect_pc are dropped.
  assign redir_tgt   = redirect_pc & ~XLEN'(3);
  assign pc_next_seq = pc_q + XLEN'(4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      kill_q   <= 1'b0;
      halt_q   <= 1'b0;
      cnt_q    <= '0;
      inst_q   <= '0;
      out_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      halt_q   <= halt_d;
      cnt_q    <= cnt_d;
      inst_q   <= inst_d;
      out_pc_q <= out_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    halt_d   = halt_q;
    cnt_d    = cnt_q;
    inst_d   = inst_q;
    out_pc_d = out_pc_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end

      S_REQ: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = redir_tgt;
          if (imem_resp_valid) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            // Response for the old PC is still in flight; drop it when it lands.
            kill_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          kill_d = 1'b0;
          if (kill_q) begin
            state_d = S_REQ;
          end else begin
            inst_d   = imem_resp_data;
            out_pc_d = pc_q;
            state_d  = S_OUT;
          end
        end
      end

      S_OUT: begin
        if (out_ready) begin
          cnt_d = cnt_q + 64'd1;
          pc_d  = redirect_valid ? redir_tgt : pc_next_seq;
          if (is_ebreak(inst_q)) begin
            halt_d  = 1'b1;
            state_d = S_HALT;
          end else begin
            state_d = S_REQ;
          end
        end else if (redirect_valid) begin
          pc_d    = redir_tgt;
          state_d = S_REQ;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_OUT);
  assign out_inst       = inst_q;
  assign out_pc         = out_pc_q;
  assign halt           = halt_q;
  assign fetch_count    = cnt_q;

endmodule
